fifo_sched: RTL

Scheduler that shares one FIFO read port and one FIFO write port between the UART controller (consumer/producer 0) and the softmax engine (consumer/producer 1).
- Read side: sequences FIFO reads and routes each word to one consumer over valid/ready, according to the 2-bit control register written over SPI.
- Write side: round-robin arbitration of two producers into one FIFO write port.
- Sits between the TX/RX FIFOs and the uart_ctl/softmax_top blocks in dut_top.

---
 rtl/fifo_sched_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 25 ++
 rtl/fifo_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types for the FIFO scheduler: control-register modes, read FSM states
// and the default data width.
package fifo_sched_pkg;

  localparam int unsigned DEF_DW = 16;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_UART   = 2'b01,
    MODE_SMAX   = 2'b10,
    MODE_SHARED = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPT,
    ST_HOLD
  } rd_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Grants the requester at or after the
// pointer; on advance the pointer stays on the winner (hold) or moves past it.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hold,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = '0;
    if (req[ptr_q])       gnt[ptr_q]  = 1'b1;
    else if (req[~ptr_q]) gnt[~ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ptr_q <= 1'b0;
    else if (adv && |gnt)   ptr_q <= hold ? gnt[1] : gnt[0];
  end

endmodule

// File: rtl/fifo_sched.sv
// Shares one FIFO read port between the UART and softmax consumers (mode
// selected by control) and round-robins two producers into one FIFO write port.
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    control,
  input  logic [DW-1:0] rd_fifo_data,
  input  logic          rd_fifo_empty,
  output logic          rd_fifo_en,
  output logic [DW-1:0] c0_data,
  output logic          c0_valid,
  input  logic          c0_ready,
  output logic [DW-1:0] c1_data,
  output logic          c1_valid,
  input  logic          c1_ready,
  output logic [DW-1:0] wr_fifo_data,
  output logic          wr_fifo_en,
  input  logic          wr_fifo_full,
  input  logic [DW-1:0] p0_data,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [DW-1:0] p1_data,
  input  logic          p1_valid,
  output logic          p1_ready,
  output logic [15:0]   rd_count,
  output logic          busy
);

  mode_e         mode;
  rd_state_e     state_q, state_d;
  logic [1:0]    elig, rd_gnt, wr_req, wr_gnt;
  logic          start, deliver, sel_d, rd_adv, rd_hold, same;
  logic          gnt_sel_q, shared_q, owner_q;
  logic [DW-1:0] out_q;
  logic [15:0]   rd_count_q;
  logic [7:0]    burst_q, burst_base;

  assign mode = mode_e'(control);

  always_comb begin
    elig = '0;
    unique case (mode)
      MODE_OFF:    elig = '0;
      MODE_UART:   elig = {1'b0, c0_ready};
      MODE_SMAX:   elig = {c1_ready, 1'b0};
      MODE_SHARED: elig = {c1_ready, c0_ready};
    endcase
  end

  assign start   = (state_q == ST_IDLE) && !rd_fifo_empty && (|elig);
  assign deliver = (state_q == ST_HOLD) && (gnt_sel_q ? c1_ready : c0_ready);
  assign sel_d   = (mode == MODE_SHARED) ? rd_gnt[1] : (mode == MODE_SMAX);
  assign rd_adv  = start && (mode == MODE_SHARED);

  // Burst continues only if the grant stays with the previous shared owner;
  // the pointer holds while words remain in the burst after this one.
  assign same       = (rd_gnt[1] == owner_q);
  assign burst_base = same ? burst_q : '0;
  assign rd_hold    = ({1'b0, burst_base} + 9'd1) < 9'(BURST_LEN);

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({c1_ready, c0_ready}),
    .hold  (rd_hold),
    .adv   (rd_adv),
    .gnt   (rd_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rd_fifo_en = 1'b0;
    c0_valid   = 1'b0;
    c1_valid   = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rd_fifo_en = 1'b1;
        state_d    = ST_CAPT;
      end
      ST_CAPT: state_d = ST_HOLD;
      ST_HOLD: begin
        c0_valid = !gnt_sel_q;
        c1_valid = gnt_sel_q;
        if (deliver) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_sel_q  <= 1'b0;
      shared_q   <= 1'b0;
      owner_q    <= 1'b0;
      out_q      <= '0;
      rd_count_q <= '0;
      burst_q    <= '0;
    end else begin
      if (start) begin
        gnt_sel_q <= sel_d;
        shared_q  <= (mode == MODE_SHARED);
      end
      if (rd_adv) begin
        owner_q <= rd_gnt[1];
        if (!same) burst_q <= '0;
      end
      if (state_q == ST_CAPT) out_q <= rd_fifo_data;
      if (deliver) begin
        rd_count_q <= rd_count_q + 16'd1;
        if (shared_q)
          burst_q <= (({1'b0, burst_q} + 9'd1) >= 9'(BURST_LEN)) ? '0 : burst_q + 8'd1;
      end
    end
  end

  assign c0_data  = c0_valid ? out_q : '0;
  assign c1_data  = c1_valid ? out_q : '0;
  assign rd_count = rd_count_q;

  assign wr_req = {p1_valid, p0_valid} & {2{rst_n & ~wr_fifo_full}};

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .hold  (1'b0),
    .adv   (1'b1),
    .gnt   (wr_gnt)
  );

  assign p0_ready     = wr_gnt[0];
  assign p1_ready     = wr_gnt[1];
  assign wr_fifo_en   = |wr_gnt;
  assign wr_fifo_data = wr_gnt[1] ? p1_data : (wr_gnt[0] ? p0_data : '0);

endmodule
